program_counter: RTL and testbench

//   Architectural program-counter register for the single-cycle MIPS-style CPU.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/program_counter_if.sv | 15 +
 rtl/program_counter.sv | 32 +++
 tb/tb_program_counter.sv | 107 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: address width and the first fetch address after reset.
package cpu_pkg;

  localparam int unsigned      ADDR_W   = 32;
  localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/program_counter_if.sv
// Next-PC / current-PC bundle between the control/next-PC logic (master) and the PC register (slave).
interface program_counter_if
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
);

  logic             PCWre;
  logic [WIDTH-1:0] PCin;
  logic [WIDTH-1:0] PCOut;

  modport master (output PCWre, output PCin, input PCOut);
  modport slave  (input PCWre, input PCin, output PCOut);

endinterface

// File: rtl/program_counter.sv
// Architectural PC register: loads the upstream next-PC when enabled and holds otherwise (halt/stall).
// The stored value is bit-exact; alignment is the responsibility of whoever produces PCin.
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  pc_bus
);

  logic [WIDTH-1:0] pc_q;

  // Synchronous reset has priority over the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VALUE;
    end else if (pc_bus.PCWre) begin
      pc_q <= pc_bus.PCin;
    end
  end

  assign pc_bus.PCOut = pc_q;

  a_reset_value : assert property (@(posedge clk) reset |=> (pc_q == RESET_VALUE));

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
                                   !pc_bus.PCWre |=> $stable(pc_q));

endmodule

// File: tb/tb_program_counter.sv
// Directed + randomized checks of the PC register against a simple next-value model.
module tb_program_counter;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;

  int total;
  int bad;

  logic [W-1:0] exp_pc;

  program_counter_if #(.WIDTH(W)) bus ();

  program_counter #(
    .WIDTH       (W),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, update the model, then compare away from the edge.
  task automatic step(input string tag, input logic r, input logic we, input logic [W-1:0] din);
    reset     = r;
    bus.PCWre = we;
    bus.PCin  = din;
    @(posedge clk);
    #1;
    if (r)       exp_pc = 32'h0000_0000;
    else if (we) exp_pc = din;
    check(tag, bus.PCOut, exp_pc);
  endtask

  initial begin
    logic         r;
    logic         we;
    logic [W-1:0] din;

    total     = 0;
    bad       = 0;
    exp_pc    = '0;
    reset     = 1'b1;
    bus.PCWre = 1'b1;
    bus.PCin  = 32'h0000_0040;
    @(negedge clk);

    // Reset wins over a pending load
    step("reset", 1'b1, 1'b1, 32'h0000_0040);

    // Consecutive loads, one cycle latency each
    step("load4", 1'b0, 1'b1, 32'h0000_0004);
    step("load8", 1'b0, 1'b1, 32'h0000_0008);

    // Hold for three edges with a different PCin presented
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 32'h0000_1234);
    step("load1234", 1'b0, 1'b1, 32'h0000_1234);

    // PCin changing between edges must not reach PCOut
    bus.PCin = 32'hCAFE_F00D;
    #2;
    check("no_comb_path", bus.PCOut, 32'h0000_1234);

    // Reset pulse that does not span an edge has no effect
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("sync_reset_pulse", bus.PCOut, 32'h0000_1234);
    step("sync_reset_held", 1'b1, 1'b0, 32'h0000_5555);

    // Extreme values stored exactly, no masking of low bits
    step("all_ones", 1'b0, 1'b1, 32'hFFFF_FFFF);
    step("low_bits", 1'b0, 1'b1, 32'h0000_0003);

    // Priority and recovery after reset
    step("prio_reset", 1'b1, 1'b1, 32'hDEAD_BEEC);
    step("prio_resume", 1'b0, 1'b1, 32'hDEAD_BEEC);
    step("hold_after", 1'b0, 1'b0, 32'h0000_0000);

    // Randomized traffic: occasional resets, mixed loads and stalls
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(0, 15) == 0);
      we  = $urandom_range(0, 1) != 0;
      din = $urandom();
      step("random", r, we, din);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
